// File: rtl/hc595_scan_ctrl.sv
// Scan controller for a 6-digit common-anode display behind two cascaded 74HC595s.
// Each scan tick serialises {seg, sel} MSB first on sh_cp/ds, then pulses st_cp.
module hc595_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int SCAN_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [23:0] data_in,
  input  logic [5:0]  point,
  input  logic        enable,
  output logic        sh_cp,
  output logic        st_cp,
  output logic        ds,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  dig_idx
);

  localparam int CNT_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] build_word(input logic [23:0] data,
                                             input logic [5:0]  dp,
                                             input logic        en,
                                             input logic [2:0]  digit);
    logic [7:0] seg;
    logic [5:0] sel;
    seg = hex_seg(data[{digit, 2'b00} +: 4]);
    if (dp[digit]) seg[7] = 1'b0;
    sel = 6'b000001 << digit;
    if (!en) begin
      seg = 8'hFF;
      sel = 6'b000000;
    end
    return {seg, sel};
  endfunction

  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             hi_q, hi_d;
  logic [3:0]       bit_q, bit_d;
  logic [2:0]       digit_q, digit_d;
  logic [13:0]      word_q;
  logic [13:0]      new_word;
  logic             load_word;

  logic             sh_cp_d, st_cp_d, ds_d, busy_d, frame_done_d;
  logic [2:0]       dig_idx_d;

  assign tick     = (cnt_q == CNT_LAST);
  assign new_word = build_word(data_in, point, enable, digit_q);

  // Free-running scan timebase; ticks that land outside IDLE are simply ignored.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hi_d         = hi_q;
    bit_d        = bit_q;
    digit_d      = digit_q;
    sh_cp_d      = sh_cp;
    st_cp_d      = st_cp;
    ds_d         = ds;
    busy_d       = busy;
    frame_done_d = 1'b0;
    dig_idx_d    = dig_idx;
    load_word    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = LOAD;
          load_word = 1'b1;
          ds_d      = new_word[13];
          sh_cp_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        div_d   = '0;
        hi_d    = 1'b0;
        bit_d   = 4'd13;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!hi_q) begin
            hi_d    = 1'b1;
            sh_cp_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            state_d = LATCH;
            hi_d    = 1'b0;
            sh_cp_d = 1'b0;
            st_cp_d = 1'b1;
          end else begin
            // Next bit goes out on the same cycle sh_cp falls, so it is stable for the next rise.
            hi_d    = 1'b0;
            sh_cp_d = 1'b0;
            bit_d   = bit_q - 4'd1;
            ds_d    = word_q[bit_q - 4'd1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          state_d      = IDLE;
          div_d        = '0;
          st_cp_d      = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          dig_idx_d    = digit_q;
          digit_d      = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered so the 595 pins never see decode glitches.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      hi_q       <= 1'b0;
      bit_q      <= 4'd0;
      digit_q    <= 3'd0;
      sh_cp      <= 1'b0;
      st_cp      <= 1'b0;
      ds         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dig_idx    <= 3'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hi_q       <= hi_d;
      bit_q      <= bit_d;
      digit_q    <= digit_d;
      sh_cp      <= sh_cp_d;
      st_cp      <= st_cp_d;
      ds         <= ds_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      dig_idx    <= dig_idx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (load_word) word_q <= new_word;
  end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Bench for hc595_scan_ctrl: scoreboarded frame words from a reference model, plus a
// second instance with a short scan period where most ticks land while busy.
module tb_hc595_scan_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int SCAN_CYC  = 100;
  localparam int BUSY_LEN  = 1 + 28*CLK_DIV + CLK_DIV;
  localparam int DROP_SCAN = 30;
  localparam int DROP_GAP  = ((BUSY_LEN + 1 + DROP_SCAN - 1) / DROP_SCAN) * DROP_SCAN;

  localparam logic [7:0] HEX_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] data_in = 24'h0;
  logic [5:0]  point = 6'h0;
  logic        enable = 1'b0;

  logic        sh_cp, st_cp, ds, busy, fd;
  logic [2:0]  dig_idx;
  logic        d_sh, d_st, d_ds, d_busy, d_fd;
  logic [2:0]  d_idx;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [13:0] word;
    logic [2:0]  dig;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hc595_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_CYC(SCAN_CYC)) u_dut (
    .sys_clk(clk), .reset_n(rst_n), .data_in(data_in), .point(point), .enable(enable),
    .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .busy(busy), .frame_done(fd), .dig_idx(dig_idx)
  );

  hc595_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_CYC(DROP_SCAN)) u_drop (
    .sys_clk(clk), .reset_n(rst_n), .data_in(data_in), .point(point), .enable(enable),
    .sh_cp(d_sh), .st_cp(d_st), .ds(d_ds), .busy(d_busy), .frame_done(d_fd), .dig_idx(d_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] model_word(input logic [23:0] d, input logic [5:0] p,
                                             input logic en, input int n);
    logic [23:0] sh;
    logic [7:0]  seg;
    logic [5:0]  sel;
    if (!en) return {8'hFF, 6'b000000};
    sh  = d >> (4*n);
    seg = HEX_TAB[sh[3:0]];
    if (p[n]) seg[7] = 1'b0;
    sel = 6'(1 << n);
    return {seg, sel};
  endfunction

  task automatic push_exp(input int n);
    exp_t e;
    e.word = model_word(data_in, point, enable, n);
    e.dig  = 3'(n);
    exp_q.push_back(e);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (fd === 1'b1) seen = 1'b1;
    end
    check("frame_seen", 32'(seen), 32'd1);
  endtask

  // Main monitor: rebuilds each frame from the pins and compares at frame_done.
  logic [13:0] m_shreg;
  int          m_rises, m_st_rises, m_st_w, m_busy_cyc;
  logic        m_sh_prev, m_st_prev, m_ds_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_shreg = '0; m_rises = 0; m_st_rises = 0; m_st_w = 0; m_busy_cyc = 0;
      m_sh_prev = 1'b0; m_st_prev = 1'b0; m_ds_prev = 1'b0;
    end else begin
      if (sh_cp && !m_sh_prev) begin
        m_shreg = {m_shreg[12:0], ds};
        m_rises++;
      end
      if (sh_cp && m_sh_prev) check("ds_stable_while_sh_high", 32'(ds), 32'(m_ds_prev));
      if (st_cp && !m_st_prev) m_st_rises++;
      if (st_cp) m_st_w++;
      if (busy) m_busy_cyc++;
      if (fd) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_word", 32'(m_shreg), 32'(e.word));
          check("dig_idx", 32'(dig_idx), 32'(e.dig));
          check("sh_cp_rises", 32'(m_rises), 32'd14);
          check("st_cp_rises", 32'(m_st_rises), 32'd1);
          check("st_cp_width", 32'(m_st_w), 32'(CLK_DIV));
          check("busy_cycles", 32'(m_busy_cyc), 32'(BUSY_LEN));
          check("busy_low_at_done", 32'(busy), 32'd0);
        end
        m_rises = 0; m_st_rises = 0; m_st_w = 0; m_busy_cyc = 0;
      end
      m_sh_prev = sh_cp; m_st_prev = st_cp; m_ds_prev = ds;
    end
  end

  // Short-period monitor: dropped ticks must not create extra or malformed frames.
  logic [13:0] d_shreg;
  int          d_rises, d_st_rises, d_gap;
  logic        d_sh_prev, d_st_prev, d_have_prev;
  logic [2:0]  d_prev_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      d_shreg = '0; d_rises = 0; d_st_rises = 0; d_gap = 0;
      d_sh_prev = 1'b0; d_st_prev = 1'b0; d_have_prev = 1'b0; d_prev_idx = 3'd0;
    end else begin
      d_gap++;
      if (d_sh && !d_sh_prev) begin
        d_shreg = {d_shreg[12:0], d_ds};
        d_rises++;
      end
      if (d_st && !d_st_prev) d_st_rises++;
      if (d_fd) begin
        check("drop_sh_cp_rises", 32'(d_rises), 32'd14);
        check("drop_st_cp_rises", 32'(d_st_rises), 32'd1);
        check("drop_busy_low", 32'(d_busy), 32'd0);
        check("drop_sel_onehot",
              32'((d_shreg[5:0] == 6'b0) || (d_shreg[5:0] == 6'(1 << d_idx))), 32'd1);
        if (d_have_prev) begin
          check("drop_frame_gap", 32'(d_gap), 32'(DROP_GAP));
          check("drop_idx_step", 32'(d_idx), 32'((d_prev_idx == 3'd5) ? 3'd0 : d_prev_idx + 3'd1));
        end
        d_have_prev = 1'b1;
        d_prev_idx  = d_idx;
        d_gap = 0; d_rises = 0; d_st_rises = 0;
      end
      d_sh_prev = d_sh; d_st_prev = d_st;
    end
  end

  initial begin
    int n;
    bit got_busy;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sh_cp", 32'(sh_cp), 32'd0);
    check("rst_st_cp", 32'(st_cp), 32'd0);
    check("rst_ds", 32'(ds), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(fd), 32'd0);
    check("rst_dig_idx", 32'(dig_idx), 32'd0);

    n = 0;
    for (int f = 0; f < 30; f++) begin
      if (f < 7) begin
        data_in = 24'h012345; point = 6'b0; enable = 1'b1;
      end else if (f == 11) begin
        data_in = {4'hE, 20'($urandom)}; point = 6'b100000; enable = 1'b1;
      end else if (f == 12) begin
        data_in = 24'($urandom); point = 6'($urandom_range(0, 63)); enable = 1'b0;
      end else begin
        data_in = 24'($urandom); point = 6'($urandom_range(0, 63));
        enable = ($urandom_range(0, 3) != 0);
      end
      push_exp(n);
      n = (n == 5) ? 0 : n + 1;
      if (f == 0) rst_n = 1'b1;
      wait_frame();
    end

    // Abort a frame in the middle of shifting.
    data_in = 24'($urandom); point = 6'($urandom_range(0, 63)); enable = 1'b1;
    got_busy = 1'b0;
    for (int k = 0; k < 300 && !got_busy; k++) begin
      @(negedge clk);
      if (busy === 1'b1) got_busy = 1'b1;
    end
    check("busy_before_abort", 32'(got_busy), 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sh_cp", 32'(sh_cp), 32'd0);
    check("abort_st_cp", 32'(st_cp), 32'd0);
    check("abort_ds", 32'(ds), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_frame_done", 32'(fd), 32'd0);
    check("abort_dig_idx", 32'(dig_idx), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("sh_cp_quiet_in_reset", 32'(sh_cp), 32'd0);
    end

    n = 0;
    for (int f = 0; f < 7; f++) begin
      data_in = 24'($urandom); point = 6'($urandom_range(0, 63));
      enable = ($urandom_range(0, 3) != 0);
      push_exp(n);
      n = (n == 5) ? 0 : n + 1;
      if (f == 0) rst_n = 1'b1;
      wait_frame();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hc595_scan_ctrl.md
Name: hc595_scan_ctrl

Overview:
Time-multiplexed scan controller for a 6-digit seven-segment display driven through a cascaded 74HC595 pair.
- On each scan tick it selects the next digit, encodes its hex nibble and decimal point, and serialises a 14-bit word onto sh_cp/ds.
- It then pulses st_cp to latch the word.
- It sits between the display-value producer and the board-level 595 pins, and owns all shift/latch sequencing.

Parameters:
CLK_DIV, 2, sys_clk cycles per sh_cp half-period; also the st_cp high width; must be >= 1.
SCAN_CYC, 50000, sys_clk cycles between scan ticks (1 ms at 50 MHz); must be > 29*CLK_DIV + 2.

Ports:
sys_clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
data_in  input  24  six hex digits; digit i = data_in[4i+3:4i].
point    input  6  decimal point enable; point[i] lights the dp of digit i.
enable   input  1  1 = display digits; 0 = shift blank words.
sh_cp    output  1  595 shift clock.
st_cp    output  1  595 storage/latch clock.
ds       output  1  595 serial data, MSB first.
busy     output  1  high from LOAD through LATCH.
frame_done  output  1  one-cycle pulse after each st_cp falls.
dig_idx  output  3  digit currently latched (0..5).

Behaviour:
Reset (async, reset_n=0):
- sh_cp=0, st_cp=0, ds=0, busy=0, frame_done=0, dig_idx=0.
- Scan counter=0; FSM=IDLE; next digit=0.
- Reset mid-shift aborts immediately. After release, the first tick shifts digit 0.

Scan counter:
- Free-runs 0..SCAN_CYC-1 and wraps.
- tick = 1 when count==SCAN_CYC-1.
- A tick arriving while busy=1 is dropped; it is not queued.

FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE -> LOAD on tick.
- LOAD (1 cycle):
  - Sample data_in, point and enable for digit n.
  - Build word[13:0] = {seg[7:0], sel[5:0]}; drive ds=word[13], sh_cp=0; set busy=1.
- SHIFT, for each bit k = 13 down to 0:
  - sh_cp low for CLK_DIV cycles with ds=word[k] stable.
  - sh_cp high for CLK_DIV cycles; ds stays unchanged while sh_cp is high.
  - ds updates to the next bit only on the cycle sh_cp returns low.
- LATCH:
  - After the 14th high phase: sh_cp=0, st_cp=1 for CLK_DIV cycles, then st_cp=0.
  - Same cycle as st_cp falls: busy=0, frame_done=1 for one cycle, dig_idx=n, n = (n==5) ? 0 : n+1; return to IDLE.
  - ds holds its last value in IDLE.
- Timing: busy lasts 1 + 28*CLK_DIV + CLK_DIV cycles. Exactly 14 sh_cp rising edges and 1 st_cp rising edge per frame.

Encoding (common anode, segment outputs active-low):
- seg = {dp,g,f,e,d,c,b,a}.
- Hex table 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- point[n]=1 clears seg[7].
- sel = one-hot, active-high, bit n.
- enable=0 at LOAD: seg=8'hFF and sel=6'b0. The digit index still advances.

Input changes: data_in, point and enable changes outside LOAD take effect on the next frame only.

Test Plan:
- Reset mid-shift: assert reset_n=0 during SHIFT -> all outputs 0 in the same cycle, no further sh_cp edges. Release -> next frame is digit 0.
- Basic frame, CLK_DIV=2, SCAN_CYC=100, data_in=24'h012345, point=0, enable=1:
  - First frame word = 14'b10010010_000001 (seg 92, sel digit0).
  - 14 sh_cp rises sampling those bits MSB first.
  - st_cp high 2 cycles; busy high 59 cycles; frame_done pulses once; dig_idx=0.
- Digit rotation: same stimulus over 7 frames -> seg sequence 92,99,B0,A4,F9,C0,92 and sel 000001..100000 then 000001. dig_idx wraps 5->0.
- Decimal point and hex: data_in[23:20]=4'hE, point=6'b100000 -> digit 5 seg=8'h06, sel=6'b100000.
- Blanking: enable=0 at LOAD -> word=14'b11111111_000000; dig_idx still advances.
- Dropped tick: SCAN_CYC=30, CLK_DIV=2 (below the minimum) -> every tick that lands while busy=1 produces no extra frame; each frame still has exactly 14 sh_cp rises and 1 st_cp pulse.
